hci_shallow_prio_scheduler: RTL and testbench
=============================================

Name: hci_shallow_prio_scheduler

Overview:
Sequences the priority between the high-priority branch (log interconnect: cores, DMA, ext) and the low-priority branch (HWPE) at the per-bank shallow arbitration stage in front of the N_MEM TCDM banks.
Monitors per-bank request/grant activity of both branches and drives a registered invert_prio_o.
Provides starvation protection for the HWPE branch plus fixed and alternating policies.
Sits beside the shallow arbitration stage inside the TCDM interconnect top level and replaces a static priority setting.

Parameters:
N_MEM, 16, number of memory banks (width of the per-bank request/grant vectors)
SW, 8, width of the stall-threshold and inversion-window counters
EW, 16, width of the saturating inversion-event counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous clear; same effect as reset
enable_i  input  1  scheduler enable; when 0, invert_prio_o is forced to 0 and state is held at NORMAL
policy_i  input  2  0=starvation-free, 1=fixed high, 2=fixed low, 3=alternate
max_stall_i  input  SW  consecutive low-branch stall cycles that trigger inversion; 0 disables inversion
inv_window_i  input  SW  inversion length in cycles; 0 is treated as 1
high_req_i  input  N_MEM  per-bank request, high branch
high_gnt_i  input  N_MEM  per-bank grant, high branch
low_req_i  input  N_MEM  per-bank request, low (HWPE) branch
low_gnt_i  input  N_MEM  per-bank grant, low branch
invert_prio_o  output  1  registered; 1 = low branch wins bank conflicts
stall_cnt_o  output  SW  current low-branch stall count
inv_events_o  output  EW  saturating count of NORMAL->INVERTED transitions

Behaviour:
- Clock/reset: one clock domain (clk_i). Reset is asynchronous, active-low (rst_ni).
- Reset / clear_i values: invert_prio_o=0, stall_cnt_o=0, inv_events_o=0, state=NORMAL, window counter=0, alternate toggle=0. clear_i has priority over every other input.
- Derived signals (combinational, same cycle):
  - low_stalled = |low_req_i AND NOT |(low_req_i & low_gnt_i)
  - conflict = |(high_req_i & low_req_i)
- Policy 1 (fixed high): invert_prio_o=0 on the next edge. Counters cleared; inv_events_o held.
- Policy 2 (fixed low): invert_prio_o=1 on the next edge. Counters cleared; inv_events_o held.
- Policy 3 (alternate): toggle flop flips on every cycle with conflict=1; invert_prio_o=toggle (registered). The toggle holds when there is no conflict.
- Policy 0 (starvation-free), FSM with states NORMAL and INVERTED:
  - NORMAL, stall counter:
    - low_stalled=1: stall_cnt increments, saturating at all-ones.
    - otherwise: stall_cnt clears to 0.
  - NORMAL -> INVERTED: taken on the edge where low_stalled=1, max_stall_i!=0 and stall_cnt+1 >= max_stall_i. On that edge:
    - window counter loads max(inv_window_i,1)
    - stall_cnt clears
    - inv_events_o increments, saturating at 2^EW-1
    - invert_prio_o goes to 1
  - INVERTED: invert_prio_o=1. Window counter decrements each cycle.
  - INVERTED -> NORMAL, taken on the edge where either:
    - window counter==1, or
    - |low_req_i==0 (early exit)
    On that edge invert_prio_o goes to 0 and stall_cnt stays 0.
  - Latency: invert_prio_o rises exactly max_stall_i cycles after the first stalled cycle of an uninterrupted stall run. It stays high exactly max(inv_window_i,1) cycles absent early exit.
- Mid-operation changes:
  - Policy change: takes effect on the next edge. FSM returns to NORMAL, window and stall counters clear.
  - enable_i=0: same as a policy change, and invert_prio_o=0.
  - Threshold inputs (max_stall_i, inv_window_i): sampled each cycle. A changed inv_window_i does not reload an active window.
- Async reset mid-INVERTED: invert_prio_o drops immediately, without waiting for a clock edge.
- Grants are observed only, never checked for consistency. A grant on a bank without a request is ignored via the AND with the request vector.

Test Plan:
- Reset/idle: rst_ni low then high, all requests 0 -> invert_prio_o=0, stall_cnt_o=0, inv_events_o=0 for 20 cycles.
- Starvation trigger: policy 0, max_stall=4, inv_window=3, low_req=0x0001 and low_gnt=0 continuously -> stall_cnt_o 1,2,3; invert_prio_o=1 on cycles 5-7, 0 on cycle 8, and the pattern repeats every 7 cycles; inv_events_o increments once per trigger.
- Early exit and reset: in INVERTED, drop low_req to 0 -> invert_prio_o=0 the next cycle. Separately, assert rst_ni low mid-window -> output 0 asynchronously.
- Grant breaks stall: max_stall=4, stall for 3 cycles, then low_gnt=0x0001 for one cycle -> stall_cnt_o returns to 0 and no inversion occurs.
- Alternate policy: policy 3, high_req=low_req=0x0003 for 4 cycles, then no conflict for 2 cycles -> invert_prio_o sequence 1,0,1,0 then held at 0.
- Fixed policies and edge values: policy 2 -> invert_prio_o=1 the next cycle. Policy 0 with max_stall=0 under permanent stall -> never inverts, and stall_cnt_o saturates at 255. inv_events_o saturates at 65535 when EW=16.

Source files
------------

// File: rtl/hci_shallow_prio_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hci_shallow_prio_scheduler_if : per-bank request/grant bundle, two branches |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
interface hci_shallow_prio_scheduler_if #(
  parameter int N_MEM = 16
);
  logic [N_MEM-1:0] high_req;
  logic [N_MEM-1:0] high_gnt;
  logic [N_MEM-1:0] low_req;
  logic [N_MEM-1:0] low_gnt;

  modport master (output high_req, high_gnt, low_req, low_gnt);
  modport slave  (input  high_req, high_gnt, low_req, low_gnt);
endinterface
`default_nettype wire

// File: rtl/hci_shallow_prio_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hci_shallow_prio_scheduler : HWPE-vs-log-interconnect bank priority control |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module hci_shallow_prio_scheduler #(
  parameter int N_MEM = 16,
  parameter int SW    = 8,
  parameter int EW    = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  input  wire logic          clear_i,
  input  wire logic          enable_i,
  input  wire logic [1:0]    policy_i,
  input  wire logic [SW-1:0] max_stall_i,
  input  wire logic [SW-1:0] inv_window_i,
  hci_shallow_prio_scheduler_if.slave bus,
  output logic               invert_prio_o,
  output logic [SW-1:0]      stall_cnt_o,
  output logic [EW-1:0]      inv_events_o
);

  localparam logic [0:0] c_st_normal   = 1'b0;
  localparam logic [0:0] c_st_inverted = 1'b1;

  localparam logic [1:0] c_pol_starve = 2'd0;
  localparam logic [1:0] c_pol_high   = 2'd1;
  localparam logic [1:0] c_pol_low    = 2'd2;
  localparam logic [1:0] c_pol_alt    = 2'd3;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [SW-1:0] win_q, win_d;
  logic [EW-1:0] inv_events_q, inv_events_d;
  logic          toggle_q, toggle_d;
  logic          invert_q, invert_d;

  logic [N_MEM-1:0] w_low_served;
  logic [N_MEM-1:0] w_conflict_vec;
  logic             w_low_stalled;
  logic             w_conflict;
  logic [SW:0]      w_stall_next;
  logic             w_trigger;
  logic             w_win_exit;
  logic [SW-1:0]    w_win_load;

  // Grants without a matching request drop out through the AND.
  assign w_low_served   = bus.low_req & bus.low_gnt;
  assign w_conflict_vec = bus.high_req & bus.low_req;
  assign w_low_stalled  = (|bus.low_req) && !(|w_low_served);
  assign w_conflict     = |w_conflict_vec;

  // One extra bit so a saturated counter still compares as reaching any threshold.
  assign w_stall_next = {1'b0, stall_cnt_q} + {{SW{1'b0}}, 1'b1};
  assign w_trigger    = w_low_stalled && (max_stall_i != '0) &&
                        (w_stall_next >= {1'b0, max_stall_i});
  assign w_win_exit   = (win_q == {{(SW-1){1'b0}}, 1'b1}) || !(|bus.low_req);
  assign w_win_load   = (inv_window_i == '0) ? {{(SW-1){1'b0}}, 1'b1} : inv_window_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= c_st_normal;
      stall_cnt_q  <= '0;
      win_q        <= '0;
      inv_events_q <= '0;
      toggle_q     <= 1'b0;
      invert_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      win_q        <= win_d;
      inv_events_q <= inv_events_d;
      toggle_q     <= toggle_d;
      invert_q     <= invert_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i || !enable_i || (policy_i != c_pol_starve)) begin
      state_d = c_st_normal;
    end else begin
      case (state_q)
        c_st_normal:   if (w_trigger)  state_d = c_st_inverted;
        c_st_inverted: if (w_win_exit) state_d = c_st_normal;
        default:       state_d = c_st_normal;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    win_d        = win_q;
    inv_events_d = inv_events_q;
    toggle_d     = toggle_q;
    invert_d     = invert_q;
    if (clear_i) begin
      stall_cnt_d  = '0;
      win_d        = '0;
      inv_events_d = '0;
      toggle_d     = 1'b0;
      invert_d     = 1'b0;
    end else if (!enable_i) begin
      stall_cnt_d = '0;
      win_d       = '0;
      invert_d    = 1'b0;
    end else begin
      case (policy_i)
        c_pol_high: begin
          stall_cnt_d = '0;
          win_d       = '0;
          invert_d    = 1'b0;
        end
        c_pol_low: begin
          stall_cnt_d = '0;
          win_d       = '0;
          invert_d    = 1'b1;
        end
        c_pol_alt: begin
          stall_cnt_d = '0;
          win_d       = '0;
          if (w_conflict) toggle_d = ~toggle_q;
          invert_d = toggle_d;
        end
        default: begin
          if (state_q == c_st_normal) begin
            win_d    = '0;
            invert_d = 1'b0;
            if (w_trigger) begin
              win_d        = w_win_load;
              stall_cnt_d  = '0;
              invert_d     = 1'b1;
              inv_events_d = (inv_events_q == {EW{1'b1}}) ? inv_events_q
                                                           : inv_events_q + {{(EW-1){1'b0}}, 1'b1};
            end else if (w_low_stalled) begin
              stall_cnt_d = (stall_cnt_q == {SW{1'b1}}) ? stall_cnt_q : w_stall_next[SW-1:0];
            end else begin
              stall_cnt_d = '0;
            end
          end else begin
            stall_cnt_d = '0;
            if (w_win_exit) begin
              win_d    = '0;
              invert_d = 1'b0;
            end else begin
              win_d    = win_q - {{(SW-1){1'b0}}, 1'b1};
              invert_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign invert_prio_o = invert_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign inv_events_o  = inv_events_q;

endmodule
`default_nettype wire

// File: tb/tb_hci_shallow_prio_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hci_shallow_prio_scheduler : directed self-checking bench               |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module tb_hci_shallow_prio_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        enable;
  logic [1:0]  policy;
  logic [7:0]  max_stall;
  logic [7:0]  inv_window;
  logic        invert_prio;
  logic [7:0]  stall_cnt;
  logic [15:0] inv_events;

  int checks = 0;
  int errors = 0;

  hci_shallow_prio_scheduler_if #(.N_MEM(16)) bus_if ();

  hci_shallow_prio_scheduler #(.N_MEM(16), .SW(8), .EW(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .enable_i      (enable),
    .policy_i      (policy),
    .max_stall_i   (max_stall),
    .inv_window_i  (inv_window),
    .bus           (bus_if),
    .invert_prio_o (invert_prio),
    .stall_cnt_o   (stall_cnt),
    .inv_events_o  (inv_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int inv, input int st, input int ev);
    check({tag, "_inv"},    {31'd0, invert_prio}, inv);
    check({tag, "_stall"},  {24'd0, stall_cnt},   st);
    check({tag, "_events"}, {16'd0, inv_events},  ev);
  endtask

  int exp_inv[14]   = '{0,0,0,1,1,1,0,0,0,0,1,1,1,0};
  int exp_stall[14] = '{1,2,3,0,0,0,0,1,2,3,0,0,0,0};
  int exp_ev[14]    = '{0,0,0,1,1,1,1,1,1,1,2,2,2,2};

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; policy = 2'd0;
    max_stall = 8'd4; inv_window = 8'd3;
    bus_if.high_req = '0; bus_if.high_gnt = '0;
    bus_if.low_req  = '0; bus_if.low_gnt  = '0;
    #3;
    check_all("reset", 0, 0, 0);
    #9 rst_n = 1'b1;
    #4;

    // Idle
    for (int i = 0; i < 20; i++) begin
      step();
      check_all($sformatf("idle%0d", i), 0, 0, 0);
    end

    // Starvation trigger, period 7
    bus_if.low_req = 16'h0001;
    for (int k = 0; k < 14; k++) begin
      step();
      check_all($sformatf("starve%0d", k + 1), exp_inv[k], exp_stall[k], exp_ev[k]);
    end

    // Early exit
    step(); check_all("pre_exit1", 0, 1, 2);
    step(); check_all("pre_exit2", 0, 2, 2);
    step(); check_all("pre_exit3", 0, 3, 2);
    step(); check_all("inv_enter", 1, 0, 3);
    bus_if.low_req = '0;
    step(); check_all("early_exit", 0, 0, 3);

    // Async reset mid-window
    bus_if.low_req = 16'h0001;
    step(); step(); step(); step();
    check_all("inv_before_rst", 1, 0, 4);
    #3 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 0, 0);
    bus_if.low_req = '0;
    #1 rst_n = 1'b1;
    step();

    // Grant breaks stall
    bus_if.low_req = 16'h0001;
    step(); step(); step();
    check_all("gnt_pre", 0, 3, 0);
    bus_if.low_gnt = 16'h0001;
    step(); check_all("gnt_break", 0, 0, 0);
    bus_if.low_gnt = '0;
    bus_if.low_req = '0;
    step(); check_all("gnt_after", 0, 0, 0);

    // Alternate policy
    policy = 2'd3;
    bus_if.high_req = 16'h0003;
    bus_if.low_req  = 16'h0003;
    step(); check({"alt1"}, {31'd0, invert_prio}, 1);
    step(); check({"alt2"}, {31'd0, invert_prio}, 0);
    step(); check({"alt3"}, {31'd0, invert_prio}, 1);
    step(); check_all("alt4", 0, 0, 0);
    bus_if.high_req = '0;
    bus_if.low_req  = '0;
    step(); check({"alt_hold1"}, {31'd0, invert_prio}, 0);
    step(); check({"alt_hold2"}, {31'd0, invert_prio}, 0);

    // Fixed policies
    policy = 2'd2;
    step(); check({"fixed_low"}, {31'd0, invert_prio}, 1);
    policy = 2'd1;
    step(); check({"fixed_high"}, {31'd0, invert_prio}, 0);

    // max_stall = 0: never inverts, counter saturates
    policy = 2'd0; max_stall = 8'd0;
    bus_if.low_req = 16'h0001;
    for (int k = 1; k <= 260; k++) begin
      step();
      check($sformatf("nostall_inv%0d", k), {31'd0, invert_prio}, 0);
      check($sformatf("nostall_cnt%0d", k), {24'd0, stall_cnt}, (k > 255) ? 255 : k);
    end

    // Window of 0 acts as 1; new window does not reload an active one
    max_stall = 8'd1; inv_window = 8'd0;
    step(); check_all("win0_a", 1, 0, 1);
    step(); check_all("win0_b", 0, 0, 1);
    step(); check_all("win0_c", 1, 0, 2);
    inv_window = 8'd5;
    step(); check_all("noreload", 0, 0, 2);
    step(); check_all("win5_enter", 1, 0, 3);
    enable = 1'b0;
    step(); check_all("disable", 0, 0, 3);
    enable = 1'b1;
    step(); check_all("reenable", 1, 0, 4);
    clear = 1'b1;
    step(); check_all("clear", 0, 0, 0);
    clear = 1'b0;
    bus_if.low_req = '0;
    step(); check_all("final", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
